notgate_seq_ctrl: RTL

NOTGATE_SEQ_CTRL -- requirements
Module: notgate_seq_ctrl

---
 rtl/notgate_seq_ctrl_if.sv | 39 +++
 rtl/notgate_seq_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/notgate_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// notgate_seq_ctrl_if
// Groups the control, stimulus/response and result signals of the inverter
// sweep controller into one bundle.
//   start, abort  : sweep request / cancel (master -> controller)
//   resp          : inverter lane outputs (master -> controller)
//   stim          : registered drive to the inverter lane inputs
//   busy, done    : sweep in progress / one-cycle completion pulse
//   pass          : last completed sweep had zero mismatches
//   err_cnt       : saturating mismatch count of the current/last sweep
//   fail_seen     : at least one mismatch in the current/last sweep
//   fail_vec      : stim value of the first mismatch
// -----------------------------------------------------------------------------
interface notgate_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] resp;
  logic [WIDTH-1:0] stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_cnt;
  logic             fail_seen;
  logic [WIDTH-1:0] fail_vec;

  // The side that requests sweeps and owns the inverter lanes
  modport master (
    output start, abort, resp,
    input  stim, busy, done, pass, err_cnt, fail_seen, fail_vec
  );

  // The sweep controller itself
  modport slave (
    input  start, abort, resp,
    output stim, busy, done, pass, err_cnt, fail_seen, fail_vec
  );
endinterface

// File: rtl/notgate_seq_ctrl.sv
// -----------------------------------------------------------------------------
// notgate_seq_ctrl
// Sweeps every WIDTH-bit pattern through a bank of inverter lanes. Each vector
// is driven for SETTLE_CYC cycles, then the lane outputs are compared against
// the bitwise inverse of the drive in a single CHECK cycle. Mismatches are
// counted (saturating at 255) and the first failing vector is captured.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : notgate_seq_ctrl_if slave modport (start/abort/resp in,
//           stim/busy/done/pass/err_cnt/fail_seen/fail_vec out)
// -----------------------------------------------------------------------------
module notgate_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  notgate_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  // Counter value seen in the final SETTLE cycle of a vector
  localparam logic [3:0]       LAST_CNT = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             fail_seen_q, fail_seen_d;
  logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
  logic             pass_q, pass_d;
  logic             mismatch;

  // Lanes are healthy when every output is the inverse of its drive
  assign mismatch = (bus.resp != ~stim_q);

  // State and result registers; reset clears everything including any
  // sweep in flight, so no done pulse can follow a reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stim_q      <= '0;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
      fail_seen_q <= 1'b0;
      fail_vec_q  <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      fail_seen_q <= fail_seen_d;
      fail_vec_q  <= fail_vec_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state and result update. Everything holds by default so results
  // stay visible in IDLE until the next accepted start.
  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
    fail_seen_d = fail_seen_q;
    fail_vec_d  = fail_vec_q;
    pass_d      = pass_q;

    unique case (state_q)
      IDLE: begin
        // abort is meaningless here, so start always wins
        if (bus.start) begin
          state_d     = SETTLE;
          stim_d      = '0;
          cnt_d       = '0;
          err_cnt_d   = '0;
          fail_seen_d = 1'b0;
          fail_vec_d  = '0;
          pass_d      = 1'b0;
        end
      end

      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        // An aborted CHECK leaves the counters untouched
        if (bus.abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              fail_vec_d  = stim_q;
            end
          end
          if (stim_q == ALL_ONES) begin
            // Last vector: stim stays at all-ones; the verdict includes
            // the mismatch (if any) just counted above
            state_d = DONE;
            pass_d  = (err_cnt_d == 8'd0);
          end else begin
            state_d = SETTLE;
            stim_d  = stim_q + WIDTH'(1);
            cnt_d   = '0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.stim      = stim_q;
  assign bus.busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.fail_seen = fail_seen_q;
  assign bus.fail_vec  = fail_vec_q;

endmodule
